// File: rtl/imm_extend_pipe_pkg.sv
// Shared constants for the immediate-extension unit: mode encodings.
package imm_extend_pipe_pkg;

  localparam int unsigned EXT_MODE_W = 2;

  // Extension modes carried on in_mode.
  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_SEXT = 2'd0,  // sign-extend
    EXT_ZEXT = 2'd1,  // zero-extend
    EXT_LUI  = 2'd2,  // zero-extend, shift into the upper field
    EXT_BR   = 2'd3   // sign-extend, word-align (x4) for branch offsets
  } ext_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode mux: turns a raw immediate field into the final
// datapath-width value. OUT_W must be at least IN_W+2.
module imm_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]      ext
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign zext = {{(OUT_W-IN_W){1'b0}}, in_imm};

  // Select the extension; shifts truncate to OUT_W, so BR silently
  // drops top sign bits when OUT_W == IN_W+2.
  always_comb begin
    ext = sext;
    case (ext_mode_e'(in_mode))
      EXT_SEXT: ext = sext;
      EXT_ZEXT: ext = zext;
      EXT_LUI:  ext = zext << IN_W;
      EXT_BR:   ext = sext << 2;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and a 2-entry
// skid buffer (slot 0 = output register, slot 1 = skid). Storage holds the
// already-extended value. in_ready depends only on registered state.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_imm,
  output logic [TAG_W-1:0]      out_tag
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] slot0_imm, slot1_imm;
  logic [TAG_W-1:0] slot0_tag, slot1_tag;
  logic             slot0_vld, slot1_vld;
  logic             in_xfer, out_xfer;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .ext     (ext)
  );

  assign in_ready  = !slot1_vld;
  assign out_valid = slot0_vld;
  assign out_imm   = slot0_imm;
  assign out_tag   = slot0_tag;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = slot0_vld && out_ready;

  // Skid-buffer update: FIFO order, slot 1 drains into slot 0 first.
  // Data registers only load on an accepted entry so a stalled output holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_vld <= 1'b0;
      slot1_vld <= 1'b0;
      slot0_imm <= '0;
      slot0_tag <= '0;
      slot1_imm <= '0;
      slot1_tag <= '0;
    end else if (flush) begin
      slot0_vld <= 1'b0;
      slot1_vld <= 1'b0;
    end else if (out_xfer) begin
      if (slot1_vld) begin
        slot0_imm <= slot1_imm;
        slot0_tag <= slot1_tag;
        slot0_vld <= 1'b1;
        slot1_vld <= in_xfer;
        if (in_xfer) begin
          slot1_imm <= ext;
          slot1_tag <= in_tag;
        end
      end else begin
        slot0_vld <= in_xfer;
        if (in_xfer) begin
          slot0_imm <= ext;
          slot0_tag <= in_tag;
        end
      end
    end else if (in_xfer) begin
      if (!slot0_vld) begin
        slot0_imm <= ext;
        slot0_tag <= in_tag;
        slot0_vld <= 1'b1;
      end else begin
        slot1_imm <= ext;
        slot1_tag <= in_tag;
        slot1_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed steps plus a random phase, checked
// against a 2-deep FIFO model holding arithmetically-extended values.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_imm;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference extension from the mode definitions, plain integer arithmetic.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint s, u;
    s = longint'($signed(imm));
    u = longint'(imm);
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // One cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic step(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic ordy, input logic fl);
    logic ix, ox;
    ent_t e;
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag;
    out_ready = ordy; flush = fl;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_imm", out_imm, q[0].imm);
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    ix = v && (q.size() < 2);
    ox = ordy && (q.size() > 0);
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (ix) begin
        e.imm = ref_ext(imm, mode);
        e.tag = tag;
        q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    q.delete();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_mode = '0; in_tag = '0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);

    // Modes, one cycle latency each
    step(1, 16'h8001, 2'd0, 5'd1, 1, 0); chk("sext_msb", out_imm, 32'hFFFF8001);
    chk("sext_tag", 32'(out_tag), 32'd1);
    step(1, 16'h8001, 2'd1, 5'd2, 1, 0); chk("zext", out_imm, 32'h00008001);
    step(1, 16'h1234, 2'd2, 5'd3, 1, 0); chk("lui", out_imm, 32'h12340000);
    step(1, 16'hFFFF, 2'd3, 5'd4, 1, 0); chk("br", out_imm, 32'hFFFFFFFC);
    chk("br_tag", 32'(out_tag), 32'd4);
    step(1, 16'h8000, 2'd0, 5'd5, 1, 0); chk("sext_only_msb", out_imm, 32'hFFFF8000);
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);
    chk("drained", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third held off, then drain in order
    step(1, 16'h0011, 2'd1, 5'd1, 0, 0);
    step(1, 16'h0022, 2'd1, 5'd2, 0, 0);
    chk("bp_full", 32'(in_ready), 32'd0);
    step(1, 16'h0033, 2'd1, 5'd3, 0, 0);
    step(1, 16'h0033, 2'd1, 5'd3, 1, 0);
    chk("bp_tag2", 32'(out_tag), 32'd2);
    step(1, 16'h0033, 2'd1, 5'd3, 1, 0);
    chk("bp_tag3", 32'(out_tag), 32'd3);
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);

    // Streaming: continuous accept and emit
    for (int i = 0; i < 8; i++) begin
      step(1, 16'(i * 16'h1111), 2'(i), 5'(i + 8), 1, 0);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);

    // Flush with both slots full plus a new offer
    step(1, 16'h00A0, 2'd0, 5'd10, 0, 0);
    step(1, 16'h00A1, 2'd0, 5'd11, 0, 0);
    step(1, 16'h00A2, 2'd0, 5'd12, 0, 1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);
    step(1, 16'h00A3, 2'd0, 5'd13, 1, 0);
    chk("post_flush_tag", 32'(out_tag), 32'd13);
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);

    // Reset with two entries held and an input offered
    step(1, 16'h00B0, 2'd0, 5'd20, 0, 0);
    step(1, 16'h00B1, 2'd0, 5'd21, 0, 0);
    in_valid = 1'b1;
    do_reset();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_imm", out_imm, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step(1, 16'h7FFF, 2'd0, 5'd7, 1, 0);
    chk("sext_pos", out_imm, 32'h00007FFF);
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);

    // Hold stability under a 5-cycle stall
    step(1, 16'hC3A5, 2'd3, 5'd9, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'(i), 2'd1, 5'd0, 0, 0);
      chk("hold_imm", out_imm, 32'hFFFF0E94);
      chk("hold_tag", 32'(out_tag), 32'd9);
    end
    step(0, 16'h0, 2'd0, 5'd0, 1, 0);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
           5'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    end
    for (int i = 0; i < 3; i++) step(0, 16'h0, 2'd0, 5'd0, 1, 0);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate-extension unit for the decode stage of the 4-stage CPU. It replaces the fixed 16->32 sign extender with a multi-mode extender: sign, zero, upper-immediate and branch-offset. Its registered output uses a valid/ready handshake and a 2-entry skid buffer, so a stalled execute stage never drops an immediate. Flush support discards wrong-path immediates after a taken branch.

Parameters:
IN_W, 16, width of raw immediate field
OUT_W, 32, datapath width of extended result; must satisfy OUT_W >= IN_W+2
TAG_W, 5, width of sideband tag (destination reg id) carried alongside the immediate

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all valid state
flush  input  1  synchronous pipeline flush; drops every held and incoming entry
in_valid  input  1  upstream presents an immediate
in_ready  output  1  unit can accept an entry this cycle
in_imm  input  IN_W  raw immediate field
in_mode  input  2  extension mode (codes in define.v)
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  extended result available
out_ready  input  1  downstream accepts result
out_imm  output  OUT_W  extended immediate
out_tag  output  TAG_W  tag matching out_imm

Behaviour:
- Modes (2 bits): EXT_SEXT=0: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits. EXT_ZEXT=1: upper bits zero. EXT_LUI=2: zero-extend, then shift left by IN_W, truncated to OUT_W. EXT_BR=3: sign-extend, then shift left by 2, truncated to OUT_W.
- Extension is computed combinationally on the input side and registered, so storage holds the final result, not the raw field.
- Storage: output register (slot 0) plus one skid register (slot 1), each with its own valid bit.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !slot1_valid. It is registered-state only; there is no combinational path from out_ready.
- Latency: one cycle from an accepted input to out_valid with an empty pipe. Throughput is 1 entry per cycle while out_ready=1.
- Update rules per cycle, with slot0/slot1 taken before the edge:
  - Out transfer and slot1 valid: slot0 <= slot1. If an input transfer also occurs, it loads into slot1; otherwise slot1 is cleared.
  - Out transfer and slot1 empty: slot0 <= the incoming entry if there is an input transfer, else slot0 is cleared.
  - No out transfer and slot0 empty: the input loads slot0.
  - No out transfer and slot0 full: the input loads slot1.
- Ordering is strictly FIFO. A simultaneous in and out transfer with slot0 full and slot1 empty keeps occupancy at 1.
- out_valid = slot0_valid. out_imm and out_tag are held stable while out_valid && !out_ready.
- flush: both valid bits cleared next cycle, and any input offered in the same cycle is discarded. Priority is reset > flush > normal operation. Data registers are not cleared by flush.
- Reset values: out_valid=0, in_ready=1 (reflects an empty skid), out_imm=0, out_tag=0, both valid bits 0.
- Reset asserted mid-transfer discards everything. The first accept is possible in the cycle after reset deasserts.
- Boundaries:
  - in_imm with only the MSB set, mode SEXT, yields all upper bits ones.
  - The EXT_BR shift drops the top two sign bits when OUT_W == IN_W+2. This is legal; there is no overflow flag.

Decomposition:
- define.v holds the `EXT_SEXT, `EXT_ZEXT, `EXT_LUI and `EXT_BR mode codes (2-bit) and the EXT_MODE_W=2 constant.
- Sub-module imm_ext_core holds the purely combinational mode mux (IN_W, OUT_W params; in_imm, in_mode -> ext).
- The top level contains only the skid/handshake logic and instantiates imm_ext_core once.

Test Plan:
- Modes, IN_W=16, OUT_W=32, out_ready=1: 16'h8001 SEXT -> 32'hFFFF8001. 16'h8001 ZEXT -> 32'h00008001. 16'h1234 LUI -> 32'h12340000. 16'hFFFF BR -> 32'hFFFFFFFC. Each appears one cycle after accept, tags preserved.
- Backpressure: out_ready=0, send tags 1,2: both accepted, then in_ready=0 and a third input (tag 3) is held off. Raise out_ready: tags 1,2,3 emerge in order on consecutive cycles with no loss.
- Simultaneous in/out: stream 8 entries with out_ready=1 continuously: out_valid stays high for 8 consecutive cycles and in_ready never drops.
- Flush with both slots full plus in_valid=1: next cycle out_valid=0, in_ready=1, and the flushed tags never appear.
- Reset mid-stream with 2 entries held: next cycle out_valid=0, out_imm=0, in_ready=1. A new entry 16'h7FFF SEXT -> 32'h00007FFF.
- Hold stability: out_ready=0 for 5 cycles with one entry held: out_imm and out_tag are unchanged across all 5 cycles.
